ahb_sram_sub: RTL

- Single-port AHB subordinate backed by an internal word-addressed register array.
- Sits directly downstream of the AHB common signal bundle.
  - Consumes manager address/control/write-data, the decoder select and the mux-returned `ready`.
  - Produces `readyOut`, `resp` and `rData` for the response mux.
- Implements the AHB two-stage pipeline (address phase → data phase) with configurable wait states and the two-cycle ERROR response.

---
 rtl/ahb_pkg.sv | 49 ++++
 rtl/ahb_lane_mask.sv | 41 ++++
 rtl/ahb_sram_sub.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer, response and burst encodings, transfer
// size codes, and a size/alignment helper used by AHB subordinates.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } resp_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_t;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  // True when the low address bits are a multiple of the transfer size.
  // Sizes above a doubleword are reported misaligned; they are rejected
  // by the size check anyway.
  function automatic logic size_aligned(input logic [2:0] size,
                                        input logic [2:0] low_addr);
    logic ok;
    case (size)
      SIZE_BYTE:  ok = 1'b1;
      SIZE_HALF:  ok = (low_addr[0] == 1'b0);
      SIZE_WORD:  ok = (low_addr[1:0] == 2'b00);
      SIZE_DWORD: ok = (low_addr[2:0] == 3'b000);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_lane_mask.sv
// Byte-enable generator: turns a transfer size and the byte offset within a
// data-bus word into the set of byte lanes that transfer touches.
module ahb_lane_mask
  import ahb_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [2:0]                     size,
  input  logic [$clog2(DataWidth/8)-1:0] offset,
  output logic [DataWidth/8-1:0]         mask
);

  localparam int NumLanes = DataWidth / 8;

  int span_s;

  // Number of bytes covered by the transfer size.
  always_comb begin
    span_s = 32'sd0;
    case (size)
      SIZE_BYTE:  span_s = 32'sd1;
      SIZE_HALF:  span_s = 32'sd2;
      SIZE_WORD:  span_s = 32'sd4;
      SIZE_DWORD: span_s = 32'sd8;
      default:    span_s = 32'sd0;
    endcase
  end

  // Lane i is enabled when it falls inside [offset, offset + span).
  always_comb begin
    mask = '0;
    for (int i = 0; i < NumLanes; i++) begin
      if ((i >= int'(offset)) && (i < (int'(offset) + span_s))) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_sram_sub.sv
// AHB subordinate fronting a word-addressed register array. Address phase is
// registered on acceptance; the data phase then runs through optional wait
// states (OKAY) or the two-cycle ERROR response.
// Optional build macro AHB_SRAM_SUB_WSTRB_EN adds a wStrb data-phase input
// that further qualifies the written byte lanes.
module ahb_sram_sub
  import ahb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int MemDepth   = 256,
  parameter int WaitStates = 0
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 sel,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 write,
  input  logic [2:0]           size,
  input  logic [2:0]           burst,
  input  logic [1:0]           trans,
  input  logic                 ready,
  input  logic [DataWidth-1:0] wData,
`ifdef AHB_SRAM_SUB_WSTRB_EN
  input  logic [DataWidth/8-1:0] wStrb,
`endif
  output logic                 readyOut,
  output logic                 resp,
  output logic [DataWidth-1:0] rData
);

  localparam int NumLanes = DataWidth / 8;
  localparam int OffW     = $clog2(NumLanes);
  localparam int IdxW     = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam logic [2:0] MaxSize = 3'(OffW);
  localparam logic [3:0] WaitCnt = 4'(WaitStates);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACT  = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;

  logic [DataWidth-1:0]  mem_q [MemDepth];

  trans_t                trans_s;
  logic [AddrWidth-1:0]  word_s;
  logic                  phase_done_s;
  logic                  accept_s;
  logic                  bad_s;
  logic                  wr_en_s;
  logic [NumLanes-1:0]   mask_s;
  logic [NumLanes-1:0]   lane_s;
  logic                  unused_s;

  // Burst type is informational only: every beat arrives with its own address.
  assign unused_s = ^burst;
  assign trans_s  = trans_t'(trans);
  assign word_s   = addr >> OffW;

  // A new address phase may be registered only when no data phase is stalling.
  always_comb begin
    phase_done_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACT, ST_ERR2: phase_done_s = 1'b1;
      ST_WAIT, ST_ERR1:         phase_done_s = 1'b0;
      default:                  phase_done_s = 1'b1;
    endcase
  end

  assign accept_s = sel && ready && phase_done_s &&
                    ((trans_s == TRANS_NONSEQ) || (trans_s == TRANS_SEQ));

  // Transfer legality: supported size, natural alignment, inside the array.
  assign bad_s = (size > MaxSize) ||
                 !size_aligned(size, addr[2:0]) ||
                 (word_s >= AddrWidth'(MemDepth));

  // Next-state and captured address-phase fields.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_IDLE, ST_ACT, ST_ERR2: begin
        if (accept_s) begin
          idx_d   = addr[OffW +: IdxW];
          off_d   = addr[OffW-1:0];
          size_d  = size;
          write_d = write;
          if (bad_s) begin
            state_d = ST_ERR1;
            cnt_d   = 4'd0;
          end else if (WaitCnt == 4'd0) begin
            state_d = ST_ACT;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WaitCnt;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Pipeline state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  ahb_lane_mask #(
    .DataWidth (DataWidth)
  ) u_lane_mask (
    .size   (size_q),
    .offset (off_q),
    .mask   (mask_s)
  );

`ifdef AHB_SRAM_SUB_WSTRB_EN
  assign lane_s = mask_s & wStrb;
`else
  assign lane_s = mask_s;
`endif

  // A reset in the completing cycle drops the write.
  assign wr_en_s = nReset && (state_q == ST_ACT) && write_q;

  // Byte-lane write of the array at the end of a write data phase.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumLanes; i++) begin
      if (wr_en_s && lane_s[i]) begin
        mem_q[idx_q][8*i +: 8] <= wData[8*i +: 8];
      end
    end
  end

  // Response signalling decoded from the data-phase state.
  always_comb begin
    readyOut = 1'b1;
    resp     = RESP_OKAY;
    case (state_q)
      ST_WAIT: begin readyOut = 1'b0; resp = RESP_OKAY;  end
      ST_ERR1: begin readyOut = 1'b0; resp = RESP_ERROR; end
      ST_ERR2: begin readyOut = 1'b1; resp = RESP_ERROR; end
      ST_IDLE, ST_ACT: begin readyOut = 1'b1; resp = RESP_OKAY; end
      default: begin readyOut = 1'b1; resp = RESP_OKAY;  end
    endcase
  end

  // Read data only in a read completion, zero otherwise.
  always_comb begin
    if ((state_q == ST_ACT) && !write_q) begin
      rData = mem_q[idx_q];
    end else begin
      rData = '0;
    end
  end

endmodule
